hop_seq_ctrl: RTL
=================

Name: hop_seq_ctrl

Overview:
- Parametrised frame sequencer for the tag-chip hopping transmitter.
- Each frame runs: a silent gap, then an oversampled BPSK preamble, then NUM_HOPS hop slots. Each hop slot is a sync window followed by a tx window that waits for the scan-chain hop_done.
- Successor to the fixed 64-hop controller. Adds configurable hop count, lengths and phase plan, one-shot/continuous modes, hop_done watchdog, enable abort, and frame/error counters.
- Drives the NCO hop phase increment, the scan-chain hop reset, the GPIO sync bit and the preamble IQ selection.

Parameters:
- PHASE_WIDTH, 24, hop phase-increment width
- HOP_CNT_WIDTH, 7, width of hop_n / hop_code_addr
- NUM_HOPS, 64, hops per frame (1..2^HOP_CNT_WIDTH)
- GAP_LEN, 16384, silent cycles before preamble (>=1)
- SYNC_LEN, 16384, cycles per hop sync window (>=2)
- PRMB_BITS, 2046, preamble bits
- PRMB_OS, 256, cycles per preamble bit (>=1)
- DATA_WIDTH, 16, IQ sample width
- PRMB_AMP, 16384, preamble amplitude
- HOP_START_PH_INC, -4194304, hop 0 phase increment
- HOP_DPH_INC, 131072, per-hop increment step
- TX_TIMEOUT, 65535, max cycles in HOP_TX before forced advance (0 disables)
- CONT_MODE, 1, 1: frames repeat while enable; 0: one frame per start

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  sequencer enable; low aborts
- start  in  1  one-cycle frame trigger, used when CONT_MODE=0
- hop_done  in  1  pulse from the hop scan controller
- prmb_bit  in  1  preamble ROM data; registered ROM, 1-cycle latency from prmb_addr
- prmb_addr  out  clog2(PRMB_BITS)  preamble ROM address
- hop_code_addr  out  HOP_CNT_WIDTH  hop code memory address, equals hop_n
- hop_rst  out  1  scan-chain/NCO hop reset
- hop_phase_inc  out  PHASE_WIDTH  current hop phase increment
- sync_sel  out  1  high in HOP_SYNC (tx muted)
- sync_gpio  out  1  high in GAP and PRMB
- prmb_valid  out  1  preamble IQ selected
- prmb_sym  out  DATA_WIDTH  +PRMB_AMP if prmb_bit else -PRMB_AMP, two's complement
- state  out  3  IDLE=0, GAP=1, PRMB=2, HOP_SYNC=3, HOP_TX=4
- hop_n  out  HOP_CNT_WIDTH  current hop index
- frame_done  out  1  one-cycle pulse at frame end
- frame_cnt  out  16  completed frames, wraps
- timeout_cnt  out  16  watchdog expiries, saturates at 0xFFFF

Behaviour:
- Reset values (asynchronous): state=IDLE, hop_n=0, hop_phase_inc=HOP_START_PH_INC, hop_rst=1. All counters, prmb_addr, frame_done, frame_cnt and timeout_cnt are 0.
- All outputs are registered except prmb_sym, sync_sel, sync_gpio and prmb_valid, which are decoded from the registers.
- IDLE: hop_rst=1, hop_n=0, hop_phase_inc=HOP_START_PH_INC. Leave for GAP (cnt=GAP_LEN-1) when enable && (CONT_MODE || start).
- GAP: stay exactly GAP_LEN cycles, then go to PRMB with prmb_addr=0 and os=0. hop_rst stays 1.
- PRMB: prmb_valid=1 for PRMB_BITS*PRMB_OS cycles.
  - os counts 0..PRMB_OS-1; on wrap, prmb_addr increments.
  - prmb_valid is asserted one cycle after PRMB entry, to absorb ROM latency; the duration is unchanged.
  - After the last bit: go to HOP_SYNC with cnt=SYNC_LEN-1.
- HOP_SYNC: exactly SYNC_LEN cycles. hop_rst=1 on the first cycle only, 0 afterwards. Then go to HOP_TX with wd=0.
- HOP_TX: hop_rst=0; wd increments each cycle.
  - Advance on hop_done, or on wd==TX_TIMEOUT-1 when TX_TIMEOUT!=0. A timeout advance increments timeout_cnt.
  - hop_done arriving in the same cycle as a timeout counts as done, not timeout.
  - On advance with hop_n<NUM_HOPS-1: hop_n++, hop_phase_inc += HOP_DPH_INC (modulo 2^PHASE_WIDTH), go to HOP_SYNC.
  - On advance at the last hop: frame_done=1 for one cycle and frame_cnt++. Go to GAP if CONT_MODE && enable, with hop_n=0 and phase reset; otherwise go to IDLE.
- hop_done is ignored outside HOP_TX.
- start is ignored outside IDLE and when CONT_MODE=1.
- enable low in any non-IDLE state: the next state is IDLE with no frame_done. hop_rst=1 from the next cycle.
- Frame length (no timeouts) = GAP_LEN + PRMB_BITS*PRMB_OS + NUM_HOPS*SYNC_LEN + sum of HOP_TX dwell + 1 IDLE cycle (first frame only).

Test Plan:
- Reset mid-HOP_TX (small params: NUM_HOPS=4, GAP_LEN=8, SYNC_LEN=4, PRMB_BITS=3, PRMB_OS=2) -> all outputs return to reset values immediately; hop_phase_inc=0xC00000.
- CONT_MODE=1, enable=1, hop_done 5 cycles after each HOP_TX entry -> state sequence GAP(8), PRMB(6), then (HOP_SYNC(4), HOP_TX(5)) x4. hop_phase_inc=0xC00000, 0xC20000, 0xC40000, 0xC60000. frame_done pulses once; the next frame starts in GAP.
- ROM bits 1,0,1 -> prmb_sym = 0x4000,0x4000,0xC000,0xC000,0x4000,0x4000 while prmb_valid.
- TX_TIMEOUT=10, hop_done never asserted -> each HOP_TX lasts 10 cycles; timeout_cnt=4 after the frame; frame_done still pulses.
- CONT_MODE=0 -> stays in IDLE until start. One frame runs, returns to IDLE, frame_cnt=1. A start pulse during HOP_SYNC has no effect.
- enable dropped in PRMB -> next state IDLE, hop_rst=1, frame_cnt unchanged, no frame_done.

Source files
------------

// File: rtl/hop_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : hop_seq_if
// Description : Bundles the control and status signals of the hop sequencer.
//               The master side is the environment: it drives enable, start,
//               hop_done and the preamble ROM data. The slave side is the
//               sequencer, which drives everything else.
// Ports       : none (clk/reset are plain ports on the sequencer)
//               master modport: enable, start, hop_done, prmb_bit (out)
//               slave  modport: same four signals as inputs, status as outputs
// Revision    : 1.0 - initial release
// ============================================================================
interface hop_seq_if #(
    parameter int PHASE_WIDTH   = 24,
    parameter int HOP_CNT_WIDTH = 7,
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 11
);
    logic                     enable;
    logic                     start;
    logic                     hop_done;
    logic                     prmb_bit;
    logic [ADDR_WIDTH-1:0]    prmb_addr;
    logic [HOP_CNT_WIDTH-1:0] hop_code_addr;
    logic                     hop_rst;
    logic [PHASE_WIDTH-1:0]   hop_phase_inc;
    logic                     sync_sel;
    logic                     sync_gpio;
    logic                     prmb_valid;
    logic [DATA_WIDTH-1:0]    prmb_sym;
    logic [2:0]               state;
    logic [HOP_CNT_WIDTH-1:0] hop_n;
    logic                     frame_done;
    logic [15:0]              frame_cnt;
    logic [15:0]              timeout_cnt;

    modport master (
        output enable, start, hop_done, prmb_bit,
        input  prmb_addr, hop_code_addr, hop_rst, hop_phase_inc, sync_sel,
               sync_gpio, prmb_valid, prmb_sym, state, hop_n, frame_done,
               frame_cnt, timeout_cnt
    );

    modport slave (
        input  enable, start, hop_done, prmb_bit,
        output prmb_addr, hop_code_addr, hop_rst, hop_phase_inc, sync_sel,
               sync_gpio, prmb_valid, prmb_sym, state, hop_n, frame_done,
               frame_cnt, timeout_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hop_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hop_seq_ctrl
// Description : Frame sequencer for the hopping transmitter. Each frame is a
//               silent gap, an oversampled BPSK preamble, then NUM_HOPS hop
//               slots (sync window + tx window closed by hop_done or by the
//               watchdog). Supports one-shot and continuous framing, enable
//               abort, and frame / watchdog-expiry counters.
// Ports       : clk   - system clock
//               reset - asynchronous active-high reset
//               bus   - hop_seq_if slave: enable/start/hop_done/prmb_bit in;
//                       ROM address, hop control, decoded selects, state,
//                       hop index, frame pulse and counters out
// Revision    : 1.0 - initial release
// ============================================================================
module hop_seq_ctrl #(
    parameter int PHASE_WIDTH      = 24,
    parameter int HOP_CNT_WIDTH    = 7,
    parameter int NUM_HOPS         = 64,
    parameter int GAP_LEN          = 16384,
    parameter int SYNC_LEN         = 16384,
    parameter int PRMB_BITS        = 2046,
    parameter int PRMB_OS          = 256,
    parameter int DATA_WIDTH       = 16,
    parameter int PRMB_AMP         = 16384,
    parameter int HOP_START_PH_INC = -4194304,
    parameter int HOP_DPH_INC      = 131072,
    parameter int TX_TIMEOUT       = 65535,
    parameter int CONT_MODE        = 1
) (
    input  logic     clk,
    input  logic     reset,
    hop_seq_if.slave bus
);
    localparam int ADDR_W  = (PRMB_BITS > 1) ? $clog2(PRMB_BITS) : 1;
    localparam int OS_W    = (PRMB_OS > 1) ? $clog2(PRMB_OS) : 1;
    localparam int LEN_MAX = (GAP_LEN > SYNC_LEN) ? GAP_LEN : SYNC_LEN;
    localparam int CNT_W   = $clog2(LEN_MAX + 1);
    localparam int WD_W    = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_GAP  = 3'd1;
    localparam logic [2:0] S_PRMB = 3'd2;
    localparam logic [2:0] S_SYNC = 3'd3;
    localparam logic [2:0] S_TX   = 3'd4;

    localparam logic                     C_CONT      = (CONT_MODE != 0);
    localparam logic                     C_WD_ON     = (TX_TIMEOUT != 0);
    localparam logic [CNT_W-1:0]         C_GAP_LOAD  = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0]         C_SYNC_LOAD = CNT_W'(SYNC_LEN - 1);
    localparam logic [OS_W-1:0]          C_OS_LAST   = OS_W'(PRMB_OS - 1);
    localparam logic [ADDR_W-1:0]        C_LAST_BIT  = ADDR_W'(PRMB_BITS - 1);
    localparam logic [WD_W-1:0]          C_WD_LAST   = WD_W'(TX_TIMEOUT - 1);
    localparam logic [HOP_CNT_WIDTH-1:0] C_LAST_HOP  = HOP_CNT_WIDTH'(NUM_HOPS - 1);
    localparam logic [PHASE_WIDTH-1:0]   C_PH_START  = PHASE_WIDTH'(HOP_START_PH_INC);
    localparam logic [PHASE_WIDTH-1:0]   C_PH_STEP   = PHASE_WIDTH'(HOP_DPH_INC);
    localparam logic [DATA_WIDTH-1:0]    C_SYM_POS   = DATA_WIDTH'(PRMB_AMP);
    localparam logic [DATA_WIDTH-1:0]    C_SYM_NEG   = DATA_WIDTH'(-PRMB_AMP);

    logic [2:0]               r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [OS_W-1:0]          r_os;
    logic [ADDR_W-1:0]        r_prmb_addr;
    logic [WD_W-1:0]          r_wd;
    logic [HOP_CNT_WIDTH-1:0] r_hop_n;
    logic [PHASE_WIDTH-1:0]   r_hop_phase_inc;
    logic                     r_hop_rst;
    logic                     r_prmb_dly;
    logic                     r_frame_done;
    logic [15:0]              r_frame_cnt;
    logic [15:0]              r_timeout_cnt;

    logic [2:0] w_state_nxt;
    logic       w_timeout;
    logic       w_advance;
    logic       w_last_hop;
    logic       w_os_wrap;
    logic       w_last_bit;
    logic       w_frame_end;
    logic       w_hop_step;
    logic       w_tmo_event;
    logic       w_hop_rst_nxt;

    assign w_timeout  = C_WD_ON && (r_wd == C_WD_LAST);
    assign w_advance  = (r_state == S_TX) && (bus.hop_done || w_timeout);
    assign w_last_hop = (r_hop_n == C_LAST_HOP);
    assign w_os_wrap  = (r_os == C_OS_LAST);
    assign w_last_bit = (r_prmb_addr == C_LAST_BIT);

    // State register and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_os            <= '0;
            r_prmb_addr     <= '0;
            r_wd            <= '0;
            r_hop_n         <= '0;
            r_hop_phase_inc <= C_PH_START;
            r_hop_rst       <= 1'b1;
            r_prmb_dly      <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_cnt     <= '0;
            r_timeout_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_hop_rst    <= w_hop_rst_nxt;
            r_frame_done <= w_frame_end;
            // ROM data trails the address by one cycle, so the valid window
            // is the PRMB residency shifted by one; an abort cancels it.
            r_prmb_dly   <= (r_state == S_PRMB) && bus.enable;

            if (w_state_nxt == S_GAP && r_state != S_GAP) begin
                r_cnt <= C_GAP_LOAD;
            end else if (w_state_nxt == S_SYNC && r_state != S_SYNC) begin
                r_cnt <= C_SYNC_LOAD;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (r_state == S_PRMB) begin
                if (w_os_wrap) begin
                    r_os <= '0;
                    if (!w_last_bit) begin
                        r_prmb_addr <= r_prmb_addr + 1'b1;
                    end
                end else begin
                    r_os <= r_os + 1'b1;
                end
            end else begin
                r_os <= '0;
                if (w_state_nxt == S_PRMB) begin
                    r_prmb_addr <= '0;
                end
            end

            r_wd <= (r_state == S_TX) ? r_wd + 1'b1 : '0;

            if (w_state_nxt == S_IDLE || w_state_nxt == S_GAP) begin
                r_hop_n         <= '0;
                r_hop_phase_inc <= C_PH_START;
            end else if (w_hop_step) begin
                r_hop_n         <= r_hop_n + 1'b1;
                r_hop_phase_inc <= r_hop_phase_inc + C_PH_STEP;
            end

            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_tmo_event && r_timeout_cnt != 16'hFFFF) begin
                r_timeout_cnt <= r_timeout_cnt + 16'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.enable && (C_CONT || bus.start)) w_state_nxt = S_GAP;
            S_GAP:  if (r_cnt == '0) w_state_nxt = S_PRMB;
            S_PRMB: if (w_os_wrap && w_last_bit) w_state_nxt = S_SYNC;
            S_SYNC: if (r_cnt == '0) w_state_nxt = S_TX;
            S_TX: begin
                if (w_advance) begin
                    if (!w_last_hop) begin
                        w_state_nxt = S_SYNC;
                    end else begin
                        w_state_nxt = C_CONT ? S_GAP : S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Dropping enable aborts from anywhere, ahead of any frame completion
        if (r_state != S_IDLE && !bus.enable) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Output logic: next values of registered outputs and decoded selects
    always_comb begin
        w_frame_end   = w_advance && w_last_hop && bus.enable;
        w_hop_step    = w_advance && !w_last_hop && bus.enable;
        // A simultaneous hop_done wins over the watchdog
        w_tmo_event   = w_advance && !bus.hop_done && bus.enable;
        w_hop_rst_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_GAP) ||
                        (w_state_nxt == S_PRMB) ||
                        ((w_state_nxt == S_SYNC) && (r_state != S_SYNC));
    end

    assign bus.prmb_addr     = r_prmb_addr;
    assign bus.hop_code_addr = r_hop_n;
    assign bus.hop_rst       = r_hop_rst;
    assign bus.hop_phase_inc = r_hop_phase_inc;
    assign bus.sync_sel      = (r_state == S_SYNC);
    assign bus.sync_gpio     = (r_state == S_GAP) || (r_state == S_PRMB);
    assign bus.prmb_valid    = r_prmb_dly;
    assign bus.prmb_sym      = bus.prmb_bit ? C_SYM_POS : C_SYM_NEG;
    assign bus.state         = r_state;
    assign bus.hop_n         = r_hop_n;
    assign bus.frame_done    = r_frame_done;
    assign bus.frame_cnt     = r_frame_cnt;
    assign bus.timeout_cnt   = r_timeout_cnt;
endmodule
`default_nettype wire
